// File: rtl/dm_responder_pkg.sv
// dm_responder_pkg: data-type and FSM encodings shared by dm_responder and its lane merger.
package dm_responder_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [2:0] {
    DT_WORD  = 3'd0,
    DT_HALF  = 3'd1,
    DT_HALFU = 3'd2,
    DT_BYTE  = 3'd3,
    DT_BYTEU = 3'd4
  } dataType_e;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  function automatic logic isHalf(input logic [2:0] t);
    return t == DT_HALF || t == DT_HALFU;
  endfunction
  function automatic logic isByte(input logic [2:0] t);
    return t == DT_BYTE || t == DT_BYTEU;
  endfunction
endpackage

// File: rtl/dm_responder_byte_lane_merge.sv
// byte_lane_merge: little-endian store merge of wd into an existing word by access type and byte offset.
module byte_lane_merge
  import dm_responder_pkg::*;
(
  input  logic [WORD_W-1:0] oldWord,
  input  logic [WORD_W-1:0] wd,
  input  logic [2:0]        dataType,
  input  logic [1:0]        byteOff,
  output logic [WORD_W-1:0] merged,
  output logic [3:0]        laneEn
);
  logic [WORD_W-1:0] rep;
  always_comb begin
    laneEn = dataType == DT_WORD ? 4'hF :
             isHalf(dataType)    ? (byteOff[1] ? 4'b1100 : 4'b0011) :
             isByte(dataType)    ? 4'b0001 << byteOff : 4'b0000;
    rep = dataType == DT_WORD ? wd : isHalf(dataType) ? {2{wd[15:0]}} : {4{wd[7:0]}};
    for (int i = 0; i < 4; i++) merged[8*i +: 8] = laneEn[i] ? rep[8*i +: 8] : oldWord[8*i +: 8];
  end
endmodule

// File: rtl/dm_responder.sv
// dm_responder: MEM-stage load/store responder with wait states, lane merge and access checking.
// Define DM_WRITE_LOG_EN to log every committed store in simulation.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        dataType,
  input  logic [31:0]       addr,
  input  logic [31:0]       wd,
  input  logic [31:0]       pc,
  output logic              ready,
  output logic [WORD_W-1:0] rd,
  output logic [2:0]        rd_extend_type,
  output logic [1:0]        byte_select,
  output logic              addr_err
);
  localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  state_e state, nextState;
  logic [CW-1:0] cnt;
  logic capWe;
  logic [2:0] capType;
  logic [31:0] capAddr, capWd;
  logic [WORD_W-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic [WORD_W-1:0] oldWord, merged;
  logic [3:0] laneEn;
  logic err, commit;
  assign idx = capAddr[ADDR_WIDTH+1:2];
  assign oldWord = mem[idx];
  always_comb begin
    err = capType > DT_BYTEU
       || (capType == DT_WORD && capAddr[1:0] != 2'b00)
       || (isHalf(capType) && capAddr[0])
       || (|capAddr[31:ADDR_WIDTH+2]);
    commit = state == S_RESP && capWe && !err && |laneEn;
  end
  byte_lane_merge uMerge (
    .oldWord (oldWord),
    .wd      (capWd),
    .dataType(capType),
    .byteOff (capAddr[1:0]),
    .merged  (merged),
    .laneEn  (laneEn)
  );
  always_comb begin
    nextState = state == S_IDLE ? (req ? (WAIT_CYCLES == 0 ? S_RESP : S_WAIT) : S_IDLE) :
                state == S_WAIT ? (cnt == '0 ? S_RESP : S_WAIT) : S_IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= nextState;
  // Outputs register on the RESP edge, so ready lands WAIT_CYCLES+1 cycles after accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready <= 1'b0;
      rd <= '0;
      rd_extend_type <= '0;
      byte_select <= '0;
      addr_err <= 1'b0;
      cnt <= '0;
      capWe <= 1'b0;
      capType <= '0;
      capAddr <= '0;
      capWd <= '0;
      for (int i = 0; i < 2**ADDR_WIDTH; i++) mem[i] <= '0;
    end else begin
      ready <= state == S_RESP;
      if (state == S_IDLE && req) begin
        capWe <= we;
        capType <= dataType;
        capAddr <= addr;
        capWd <= wd;
        cnt <= CW'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
      end
      if (state == S_WAIT) cnt <= cnt - 1'b1;
      if (state == S_RESP) begin
        rd <= err ? '0 : capWe ? merged : oldWord;
        addr_err <= err;
        rd_extend_type <= capType;
        byte_select <= capAddr[1:0];
      end
      if (commit) mem[idx] <= merged;
    end
  end
`ifdef DM_WRITE_LOG_EN
  logic [31:0] capPc;
  always_ff @(posedge clk or posedge reset)
    if (reset) capPc <= '0;
    else if (state == S_IDLE && req) capPc <= pc;
  always @(posedge clk)
    if (!reset && commit) $display("%0t @%h: *%h <= %h", $time, capPc, {capAddr[31:2], 2'b00}, merged);
`else
  logic unusedPc;
  assign unusedPc = ^pc;
`endif
endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Memory-side responder to the pipeline's MEM-stage load/store request.
- Accepts one word, halfword or byte access per req/ready handshake and inserts a configurable number of wait states.
- Performs byte-lane merging on stores and returns the full aligned word on loads, together with the extend type and byte select that WB uses to extract the result.
- Flags misaligned, out-of-range and illegal-type accesses.

Parameters:
- ADDR_WIDTH, 12, word-index bits; the memory holds 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2, extra cycles between acceptance and ready; 0 is legal.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- req  in  1  access request; held high with stable fields until ready.
- we  in  1  1 = store, 0 = load.
- type  in  3  data type: 0 word, 1 half signed, 2 half unsigned, 3 byte signed, 4 byte unsigned; 5-7 illegal.
- addr  in  32  byte address.
- wd  in  32  store data; the low byte/half is used for byte/half stores.
- pc  in  32  PC of the requesting instruction, used for logging only.
- ready  out  1  one-cycle completion pulse.
- rd  out  32  aligned word read, valid while ready is high.
- rd_extend_type  out  3  copy of the type of the completed access.
- byte_select  out  2  addr[1:0] of the completed access.
- addr_err  out  1  valid with ready; the access was rejected.

Behaviour:
- Reset (async, active-high):
  - FSM goes to IDLE.
  - ready=0, addr_err=0, rd=0, rd_extend_type=0, byte_select=0.
  - Wait counter = 0; all memory words = 0.
  - Assertion mid-transaction aborts the access with no write and no ready.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: when req=1, capture we, type, addr, wd and pc.
    - WAIT_CYCLES=0: go to RESP.
    - Otherwise load the counter with WAIT_CYCLES-1 and go to WAIT.
  - WAIT: decrement the counter; at 0 go to RESP.
  - RESP:
    - ready=1 for exactly one cycle.
    - Store commits on this edge.
    - rd, addr_err, rd_extend_type and byte_select are registered outputs.
    - Next state is IDLE.
    - req sampled high in RESP is ignored; a new request is accepted in IDLE only.
- Latency from accept to ready:
  - WAIT_CYCLES+1 cycles.
  - Back-to-back accesses have a throughput of one per WAIT_CYCLES+2 cycles.
- Error check (evaluated on captured fields):
  - illegal type;
  - word access with addr[1:0]!=0;
  - half access with addr[0]!=0;
  - addr[31:ADDR_WIDTH+2]!=0.
  - On error: addr_err=1 with ready, no memory write, rd=0.
- Store merge (index = addr[ADDR_WIDTH+1:2]):
  - word: all 4 lanes.
  - half: lanes {addr[1],0} and {addr[1],1} get wd[15:0], little-endian.
  - byte: lane addr[1:0] gets wd[7:0].
  - Other lanes are unchanged.
  - For stores, rd returns the post-merge word.
- Load: rd = the stored word; no extension is done here.
- Store then load of the same address in consecutive transactions must return the new data.

Optional Feature:
- Macro DM_WRITE_LOG_EN.
- Defined: on every committed store, emit in simulation `"@<pc hex>: *<aligned byte addr hex> <= <merged word hex>"`, time-stamped.
- Undefined: no display code is generated; pc is unused. Functional behaviour is identical.

Decomposition:
- Shared package/macro header holds:
  - data-type encodings (DT_WORD, DT_HALF, DT_HALFU, DT_BYTE, DT_BYTEU);
  - FSM state encodings;
  - the Word width constant.
- Sub-module byte_lane_merge: combinational (old word, wd, type, addr[1:0]) -> merged word plus 4-bit lane enable. It is reused by any future cache fill path.

Test Plan:
- Reset, then load word at 0x0 with WAIT_CYCLES=2 -> ready exactly 3 cycles after accept, rd=0, addr_err=0.
- Store word 0x12345678 at 0x10, then store byte 0xAB (type 3) at 0x12 -> later load word at 0x10 returns 0x12AB5678, byte_select=0.
- Store half 0xBEEF (type 1) at 0x22, then load half unsigned at 0x22 -> rd=0xBEEF0000, rd_extend_type=2, byte_select=2.
- Word store at 0x13, half at 0x21, type 6, and addr 0x00004000 with ADDR_WIDTH=12 -> each gives ready with addr_err=1, and target memory is unchanged on re-read.
- Assert reset during WAIT of a store of 0xFFFFFFFF to 0x4 -> no ready pulse; subsequent load of 0x4 returns 0.
- WAIT_CYCLES=0, with req held high continuously for 4 loads -> ready on every second cycle, 4 pulses, no duplicated accept.
